// File: rtl/control_pkg.sv
// control_pkg: shared encodings for the multicycle ARM main control unit.
//   - FSM state encodings S_INIT..S_BRANCH (4-bit, also the debug State value)
//   - ALUSrcB, ResultSrc, ALU command and Op field codes
package control_pkg;

   // FSM state encodings (legacy-compatible constants)
   localparam logic [3:0] S_INIT   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXECR  = 4'd7;
   localparam logic [3:0] S_EXECI  = 4'd8;
   localparam logic [3:0] S_ALUWB  = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;
   localparam logic [1:0] SRCB_4   = 2'b10;

   // Register-file write-data / PC source select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // ALUControl codes
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Instr[27:26]
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Data-processing cmd field, Instr[24:21]
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALU control decode for data-processing execute.
//   Funct[4:0]  in  : cmd[3:0] (Funct[4:1]) and S bit (Funct[0])
//   ALUOp       in  : 1 in EXECR/EXECI, enables the decode
//   ALUControl  out : ADD/SUB/AND/ORR; ADD when ALUOp is 0 or cmd unsupported
//   FlagW       out : raw flag-update enable (S bit), 0 when ALUOp is 0
module alu_decoder
   import control_pkg::*;
(
   input  logic [4:0] Funct,
   input  logic       ALUOp,
   output logic [1:0] ALUControl,
   output logic       FlagW
);

   always_comb begin
      ALUControl = ALU_ADD;
      FlagW      = 1'b0;
      if (ALUOp) begin
         case (Funct[4:1])
            CMD_ADD: ALUControl = ALU_ADD;
            CMD_SUB: ALUControl = ALU_SUB;
            CMD_AND: ALUControl = ALU_AND;
            CMD_ORR: ALUControl = ALU_ORR;
            default: ALUControl = ALU_ADD;
         endcase
         FlagW = Funct[0];
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore main control FSM for the multicycle ARM datapath.
//   CLK, RESET        : clock (rising edge), async active-high reset
//   Op, Funct, Rd     : Instr[27:26], Instr[25:20], Instr[15:12]; sampled from DECODE on
//   PCS, RegW, MemW,
//   FlagW             : raw write enables, qualified downstream by CondEx
//   NextPC, IRWrite   : fetch-cycle PC increment and instruction-register load
//   AdrSrc, ALUSrcA,
//   ALUSrcB, ResultSrc: datapath mux selects
//   ALUControl        : ALU operation
//   State             : current state, for debug
module multicycle_control_fsm
   import control_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   input  logic [3:0]         Rd,
   output logic               PCS,
   output logic               RegW,
   output logic               MemW,
   output logic               FlagW,
   output logic               NextPC,
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUControl,
   output logic [STATE_W-1:0] State
);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic       alu_op;

   // Reset forces INIT immediately, so every enable drops mid-cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= S_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_INIT;
      case (state)
         S_INIT:   state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_MEM:  state_nxt = S_MEMADR;
               OP_DP:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   state_nxt = S_BRANCH;
               default: state_nxt = S_FETCH;   // undefined: drop it, no writes
            endcase
         end
         S_MEMADR: state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_nxt = S_MEMWB;
         S_MEMWB:  state_nxt = S_FETCH;
         S_MEMWR:  state_nxt = S_FETCH;
         S_EXECR:  state_nxt = S_ALUWB;
         S_EXECI:  state_nxt = S_ALUWB;
         S_ALUWB:  state_nxt = S_FETCH;
         S_BRANCH: state_nxt = S_FETCH;
         default:  state_nxt = S_INIT;
      endcase
   end

   assign alu_op = (state == S_EXECR) || (state == S_EXECI);

   // ALUControl is ADD outside execute, which also covers FETCH/DECODE/MEMADR/BRANCH.
   alu_decoder u_alu_decoder (
      .Funct      (Funct[4:0]),
      .ALUOp      (alu_op),
      .ALUControl (ALUControl),
      .FlagW      (FlagW)
   );

   always_comb begin
      RegW      = 1'b0;
      MemW      = 1'b0;
      NextPC    = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      case (state)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_4;
            ResultSrc = RES_ALU;
            IRWrite   = 1'b1;
            NextPC    = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_4;
            ResultSrc = RES_ALU;
         end
         S_MEMADR: ALUSrcB = SRCB_IMM;
         S_MEMRD:  AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegW      = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         S_EXECR:  ALUSrcB = SRCB_REG;
         S_EXECI:  ALUSrcB = SRCB_IMM;
         S_ALUWB:  RegW    = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALU;
         end
         default: ;
      endcase
   end

   assign PCS   = (RegW && (Rd == 4'd15)) || (state == S_BRANCH);
   assign State = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed self-checking bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] ALUSrcB, ResultSrc, ALUControl;
   logic [3:0] State;
   logic [13:0] outs;

   always #5 CLK = ~CLK;

   multicycle_control_fsm #(.STATE_W(4)) dut (
      .CLK(CLK), .RESET(RESET), .Op(Op), .Funct(Funct), .Rd(Rd),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
      .NextPC(NextPC), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .State(State)
   );

   // {PCS,RegW,MemW,FlagW,NextPC,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
   assign outs = {PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ALUControl};

   localparam logic [13:0] V_INIT      = 14'b0_0_0_0_0_0_0_0_00_00_00;
   localparam logic [13:0] V_FETCH     = 14'b0_0_0_0_1_1_0_1_10_10_00;
   localparam logic [13:0] V_DECODE    = 14'b0_0_0_0_0_0_0_1_10_10_00;
   localparam logic [13:0] V_MEMADR    = 14'b0_0_0_0_0_0_0_0_01_00_00;
   localparam logic [13:0] V_MEMRD     = 14'b0_0_0_0_0_0_1_0_00_00_00;
   localparam logic [13:0] V_MEMWB_PC  = 14'b1_1_0_0_0_0_0_0_00_01_00;
   localparam logic [13:0] V_MEMWR     = 14'b0_0_1_0_0_0_1_0_00_00_00;
   localparam logic [13:0] V_BRANCH    = 14'b1_0_0_0_0_0_0_0_01_10_00;
   localparam logic [13:0] V_EXECI_ADDS= 14'b0_0_0_1_0_0_0_0_01_00_00;
   localparam logic [13:0] V_EXECI_AND = 14'b0_0_0_0_0_0_0_0_01_00_10;
   localparam logic [13:0] V_EXECR_SUB = 14'b0_0_0_0_0_0_0_0_00_00_01;
   localparam logic [13:0] V_EXECR_ORRS= 14'b0_0_0_1_0_0_0_0_00_00_11;
   localparam logic [13:0] V_EXECR_MOV = 14'b0_0_0_0_0_0_0_0_00_00_00;
   localparam logic [13:0] V_WB        = 14'b0_1_0_0_0_0_0_0_00_00_00;
   localparam logic [13:0] V_WB_PC     = 14'b1_1_0_0_0_0_0_0_00_00_00;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Check the current cycle (called at a falling edge), then advance one cycle.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [13:0] ov);
      check({tag, "/state"}, 32'(State), 32'(st));
      check({tag, "/outs"},  32'(outs),  32'(ov));
      @(negedge CLK);
   endtask

   task automatic load(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
      Op    = op;
      Funct = funct;
      Rd    = rd;
   endtask

   initial begin
      RESET = 1'b1;
      load(2'b00, 6'b000000, 4'd0);

      @(negedge CLK);
      repeat (3) cyc("reset", 4'd0, V_INIT);
      RESET = 1'b0;
      cyc("release", 4'd0, V_INIT);

      // ADDS R1, imm: 1,2,8,9
      load(2'b00, 6'b101001, 4'd1);
      cyc("adds_fetch",  4'd1, V_FETCH);
      cyc("adds_decode", 4'd2, V_DECODE);
      cyc("adds_execi",  4'd8, V_EXECI_ADDS);
      cyc("adds_aluwb",  4'd9, V_WB);

      // LDR R15: 1,2,3,4,5
      load(2'b01, 6'b011001, 4'd15);
      cyc("ldr_fetch",  4'd1, V_FETCH);
      cyc("ldr_decode", 4'd2, V_DECODE);
      cyc("ldr_memadr", 4'd3, V_MEMADR);
      cyc("ldr_memrd",  4'd4, V_MEMRD);
      cyc("ldr_memwb",  4'd5, V_MEMWB_PC);

      // STR with Rd=15: 1,2,3,6, never PCS
      load(2'b01, 6'b011000, 4'd15);
      cyc("str_fetch",  4'd1, V_FETCH);
      cyc("str_decode", 4'd2, V_DECODE);
      cyc("str_memadr", 4'd3, V_MEMADR);
      cyc("str_memwr",  4'd6, V_MEMWR);

      // B: 1,2,10
      load(2'b10, 6'b000000, 4'd0);
      cyc("b_fetch",  4'd1, V_FETCH);
      cyc("b_decode", 4'd2, V_DECODE);
      cyc("b_branch", 4'd10, V_BRANCH);

      // SUB R2, reg, no S: 1,2,7,9
      load(2'b00, 6'b000100, 4'd2);
      cyc("sub_fetch",  4'd1, V_FETCH);
      cyc("sub_decode", 4'd2, V_DECODE);
      cyc("sub_execr",  4'd7, V_EXECR_SUB);
      cyc("sub_aluwb",  4'd9, V_WB);

      // ORRS R15, reg: PCS in ALUWB
      load(2'b00, 6'b011001, 4'd15);
      cyc("orrs_fetch",  4'd1, V_FETCH);
      cyc("orrs_decode", 4'd2, V_DECODE);
      cyc("orrs_execr",  4'd7, V_EXECR_ORRS);
      cyc("orrs_aluwb",  4'd9, V_WB_PC);

      // AND R3, imm
      load(2'b00, 6'b100000, 4'd3);
      cyc("and_fetch",  4'd1, V_FETCH);
      cyc("and_decode", 4'd2, V_DECODE);
      cyc("and_execi",  4'd8, V_EXECI_AND);
      cyc("and_aluwb",  4'd9, V_WB);

      // Unsupported cmd 1101 decodes to ADD
      load(2'b00, 6'b011010, 4'd4);
      cyc("mov_fetch",  4'd1, V_FETCH);
      cyc("mov_decode", 4'd2, V_DECODE);
      cyc("mov_execr",  4'd7, V_EXECR_MOV);
      cyc("mov_aluwb",  4'd9, V_WB);

      // Undefined Op=11, Rd=15: 1,2 then back to FETCH with no enables
      load(2'b11, 6'b111111, 4'd15);
      cyc("undef_fetch",  4'd1, V_FETCH);
      cyc("undef_decode", 4'd2, V_DECODE);

      // Async reset in the middle of EXECR
      load(2'b00, 6'b000100, 4'd5);
      cyc("abort_fetch",  4'd1, V_FETCH);
      cyc("abort_decode", 4'd2, V_DECODE);
      check("abort_execr/state", 32'(State), 32'd7);
      #1 RESET = 1'b1;
      #1;
      check("abort_async/state", 32'(State), 32'd0);
      check("abort_async/outs",  32'(outs),  32'(V_INIT));
      @(negedge CLK);
      check("abort_held/state", 32'(State), 32'd0);
      check("abort_held/regw",  32'(RegW),  32'd0);
      RESET = 1'b0;
      cyc("abort_release", 4'd0, V_INIT);
      cyc("abort_refetch", 4'd1, V_FETCH);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
